// File: rtl/tc_encoder_pkg.sv
// Shared types and widths for the tc_priority_encoder3 arbiter.
package tc_encoder_pkg;
    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Index arithmetic is modulo REQ_W; the 3-bit width wraps 7 to 0 on its own.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction
endpackage

// File: rtl/tc_rr_pick8.sv
// Combinational picker: first set pending bit searching upward from a base
// index (ptr in rotating mode, 0 in fixed mode), wrapping from 7 to 0.
module tc_rr_pick8
    import tc_encoder_pkg::*;
(
    input  logic [REQ_W-1:0] i_pending,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_mode,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_cand;

    assign w_base = i_mode ? i_ptr : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        // Scan from the farthest offset down so the nearest hit is written last.
        for (int k = REQ_W - 1; k >= 0; k--) begin
            w_cand = w_base + IDX_W'(k);
            if (i_pending[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tc_priority_encoder3.sv
// Sticky-request arbiter: captures requests into a pending register and
// offers one index at a time with a valid/ack handshake.
module tc_priority_encoder3
    import tc_encoder_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in5,
    input  logic in6,
    input  logic in7,
    input  logic dis,
    input  logic ack,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic valid,
    output logic busy
);
    state_t           r_state;
    logic [REQ_W-1:0] r_pending;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_busy;

    logic [REQ_W-1:0] w_req;
    logic [REQ_W-1:0] w_clear;
    logic [REQ_W-1:0] w_pending_nxt;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic             w_accept;
    logic             w_mode;

    assign w_req    = {in7, in6, in5, in4, in3, in2, in1, in0};
    assign w_mode   = (ROUND_ROBIN != 0);
    assign w_accept = (r_state == OFFER) && ack;
    assign w_clear  = w_accept ? (REQ_W'(1) << r_idx) : '0;
    // A request arriving in the accept cycle re-sets the bit being cleared.
    assign w_pending_nxt = (r_pending & ~w_clear) | w_req;

    tc_rr_pick8 u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .i_mode    (w_mode),
        .o_idx     (w_pick_idx),
        .o_found   (w_pick_found)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_busy    <= |w_pending_nxt;
            unique case (r_state)
                IDLE: begin
                    if (!dis && w_pick_found) begin
                        r_state <= OFFER;
                        r_valid <= 1'b1;
                        r_idx   <= w_pick_idx;
                    end
                end
                OFFER: begin
                    if (ack) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ptr   <= idx_inc(r_idx);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign {out2, out1, out0} = r_idx;
    assign valid              = r_valid;
    assign busy               = r_busy;
endmodule

// File: tb/tb_tc_priority_encoder3.sv
// Self-checking bench: one rotating and one fixed-priority instance share
// stimulus; directed vectors plus random traffic checked against a model.
module tb_tc_priority_encoder3;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = '0;
    logic       dis = 1'b0;
    logic       ack = 1'b0;

    logic [2:0] rr_idx, fx_idx;
    logic       rr_valid, rr_busy, fx_valid, fx_busy;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    tc_priority_encoder3 #(.ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .in4(req[4]), .in5(req[5]), .in6(req[6]), .in7(req[7]),
        .dis(dis), .ack(ack),
        .out0(rr_idx[0]), .out1(rr_idx[1]), .out2(rr_idx[2]),
        .valid(rr_valid), .busy(rr_busy)
    );

    tc_priority_encoder3 #(.ROUND_ROBIN(0)) dut_fx (
        .clk(clk), .rst(rst),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .in4(req[4]), .in5(req[5]), .in6(req[6]), .in7(req[7]),
        .dis(dis), .ack(ack),
        .out0(fx_idx[0]), .out1(fx_idx[1]), .out2(fx_idx[2]),
        .valid(fx_valid), .busy(fx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit pend[8];
        bit offering;
        int idx;
        int ptr;
    } model_t;

    model_t mdl_rr, mdl_fx;

    function automatic model_t model_reset();
        model_t m;
        foreach (m.pend[i]) m.pend[i] = 1'b0;
        m.offering = 1'b0;
        m.idx      = 0;
        m.ptr      = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input logic [7:0] r,
                                          input logic d, input logic a, input bit rotate);
        model_t n = m;
        bit     found = 1'b0;
        if (m.offering) begin
            if (a) begin
                n.offering   = 1'b0;
                n.pend[m.idx] = 1'b0;
                n.ptr        = (m.idx + 1) % 8;
            end
        end else if (!d) begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = rotate ? (m.ptr + k) % 8 : k;
                if (!found && m.pend[j]) begin
                    found      = 1'b1;
                    n.offering = 1'b1;
                    n.idx      = j;
                end
            end
        end
        for (int i = 0; i < 8; i++) if (r[i]) n.pend[i] = 1'b1;
        return n;
    endfunction

    function automatic bit model_busy(input model_t m);
        int cnt = 0;
        foreach (m.pend[i]) cnt += int'(m.pend[i]);
        return cnt != 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_rr <= model_reset();
            mdl_fx <= model_reset();
        end else begin
            mdl_rr <= model_step(mdl_rr, req, dis, ack, 1'b1);
            mdl_fx <= model_step(mdl_fx, req, dis, ack, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mdl_rr_valid", rr_valid, mdl_rr.offering);
            check("mdl_rr_idx",   rr_idx,   mdl_rr.idx);
            check("mdl_rr_busy",  rr_busy,  model_busy(mdl_rr));
            check("mdl_fx_valid", fx_valid, mdl_fx.offering);
            check("mdl_fx_idx",   fx_idx,   mdl_fx.idx);
            check("mdl_fx_busy",  fx_busy,  model_busy(mdl_fx));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       dis;
        logic       ack;
        logic       ev;
        logic       eb;
        logic [2:0] eir;
        logic [2:0] eif;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] q, input logic d, input logic a,
                       input logic ev, input logic eb, input logic [2:0] eir, input logic [2:0] eif);
        vec_t v;
        v.rst = r; v.req = q; v.dis = d; v.ack = a;
        v.ev = ev; v.eb = eb; v.eir = eir; v.eif = eif;
        tbl.push_back(v);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic drive(input logic r, input logic [7:0] q, input logic d, input logic a);
        #1;
        rst = r; req = q; dis = d; ack = a;
        @(negedge clk);
    endtask

    int g2_fx, g4_fx, g2_rr, g4_rr;

    initial begin
        //  rst req    dis ack  valid busy idx_rr idx_fx
        add(1, 8'h00, 0, 1,   0, 0, 3'd0, 3'd0);
        // single pulse on line 3, ack held high
        add(0, 8'h08, 0, 1,   0, 1, 3'd0, 3'd0);
        add(0, 8'h00, 0, 1,   1, 1, 3'd3, 3'd3);
        add(0, 8'h00, 0, 1,   0, 0, 3'd3, 3'd3);
        // lines 1, 5, 6 together: grants 1, 5, 6 with an idle cycle between
        add(1, 8'h00, 0, 1,   0, 0, 3'd0, 3'd0);
        add(0, 8'h62, 0, 1,   0, 1, 3'd0, 3'd0);
        add(0, 8'h00, 0, 1,   1, 1, 3'd1, 3'd1);
        add(0, 8'h00, 0, 1,   0, 1, 3'd1, 3'd1);
        add(0, 8'h00, 0, 1,   1, 1, 3'd5, 3'd5);
        add(0, 8'h00, 0, 1,   0, 1, 3'd5, 3'd5);
        add(0, 8'h00, 0, 1,   1, 1, 3'd6, 3'd6);
        add(0, 8'h00, 0, 1,   0, 0, 3'd6, 3'd6);
        // ptr is 7: rotating grants 7 then 0, fixed grants 0 then 7
        add(0, 8'h81, 0, 1,   0, 1, 3'd6, 3'd6);
        add(0, 8'h00, 0, 1,   1, 1, 3'd7, 3'd0);
        add(0, 8'h00, 0, 1,   0, 1, 3'd7, 3'd0);
        add(0, 8'h00, 0, 1,   1, 1, 3'd0, 3'd7);
        add(0, 8'h00, 0, 1,   0, 0, 3'd0, 3'd7);
        // ptr wrapped to 1: rotating picks 1 before 0
        add(0, 8'h03, 0, 1,   0, 1, 3'd0, 3'd7);
        add(0, 8'h00, 0, 1,   1, 1, 3'd1, 3'd0);
        add(0, 8'h00, 0, 1,   0, 1, 3'd1, 3'd0);
        add(0, 8'h00, 0, 1,   1, 1, 3'd0, 3'd1);
        add(0, 8'h00, 0, 1,   0, 0, 3'd0, 3'd1);
        // dis blocks the offer but capture continues
        add(0, 8'h01, 1, 1,   0, 1, 3'd0, 3'd1);
        add(0, 8'h00, 1, 1,   0, 1, 3'd0, 3'd1);
        add(0, 8'h00, 1, 1,   0, 1, 3'd0, 3'd1);
        add(0, 8'h00, 0, 1,   1, 1, 3'd0, 3'd0);
        // dis raised during an offer: offer holds, then completes on ack
        add(0, 8'h10, 1, 0,   1, 1, 3'd0, 3'd0);
        add(0, 8'h00, 1, 0,   1, 1, 3'd0, 3'd0);
        add(0, 8'h00, 1, 1,   0, 1, 3'd0, 3'd0);
        add(0, 8'h00, 0, 1,   1, 1, 3'd4, 3'd4);
        add(0, 8'h00, 0, 1,   0, 0, 3'd4, 3'd4);

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].dis, tbl[i].ack);
            check($sformatf("vec%0d_rr_valid", i), rr_valid, tbl[i].ev);
            check($sformatf("vec%0d_rr_busy", i),  rr_busy,  tbl[i].eb);
            check($sformatf("vec%0d_rr_idx", i),   rr_idx,   tbl[i].eir);
            check($sformatf("vec%0d_fx_valid", i), fx_valid, tbl[i].ev);
            check($sformatf("vec%0d_fx_busy", i),  fx_busy,  tbl[i].eb);
            check($sformatf("vec%0d_fx_idx", i),   fx_idx,   tbl[i].eif);
            mon_en = 1'b1;
        end

        // Lines 2 and 4 held: fixed mode starves 4, rotating mode alternates.
        drive(1, 8'h00, 0, 1);
        g2_fx = 0; g4_fx = 0; g2_rr = 0; g4_rr = 0;
        for (int c = 0; c < 16; c++) begin
            drive(0, 8'h14, 0, 1);
            if (fx_valid === 1'b1) begin
                if (fx_idx == 3'd2) g2_fx++;
                if (fx_idx == 3'd4) g4_fx++;
            end
            if (rr_valid === 1'b1) begin
                if (rr_idx == 3'd2) g2_rr++;
                if (rr_idx == 3'd4) g4_rr++;
            end
        end
        check("starve_fx_no4",    g4_fx, 0);
        check("starve_fx_many2",  32'(g2_fx >= 6), 1);
        check("starve_rr_some4",  32'(g4_rr >= 3), 1);
        check("starve_rr_some2",  32'(g2_rr >= 3), 1);

        // Reset in the middle of an offer on index 5.
        drive(1, 8'h00, 0, 0);
        drive(0, 8'h20, 0, 0);
        drive(0, 8'h00, 0, 0);
        check("rst_pre_valid", rr_valid, 1'b1);
        check("rst_pre_idx",   rr_idx,   3'd5);
        #2 rst = 1'b1;
        #1;
        check("rst_async_rr", {rr_valid, rr_busy, rr_idx}, 5'b0);
        check("rst_async_fx", {fx_valid, fx_busy, fx_idx}, 5'b0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            drive(0, 8'h00, 0, 1);
            check("rst_after_valid", rr_valid | fx_valid, 1'b0);
            check("rst_after_busy",  rr_busy | fx_busy,   1'b0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            drive(($urandom_range(99) == 0), 8'($urandom) & 8'($urandom),
                  ($urandom_range(3) == 0), 1'($urandom_range(1)));
        end
        drive(0, 8'h00, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
